// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: states, opcodes,
// datapath mux codes, fault codes and the packed per-cycle strobe bundle.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    FAULT    = 4'd10
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10} alu_op_t;
  typedef enum logic [1:0] {
    SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11
  } src_b_t;
  typedef enum logic [1:0] {PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10} pc_src_t;
  typedef enum logic [1:0] {
    FAULT_NONE = 2'b00, FAULT_ILLEGAL = 2'b01, FAULT_TIMEOUT = 2'b10
  } fault_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    pc_src_t pc_source;
    logic    i_or_d;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    reg_dst;
    logic    mem_to_reg;
    logic    reg_write;
    logic    alu_src_a;
    src_b_t  alu_src_b;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Controller <-> datapath bundle: memory handshake and opcode in, strobes and status out.
interface mc_control_fsm_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [3:0]       state;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] retired_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           state, fault_code, retired_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           state, fault_code, retired_count
  );
endinterface

// File: rtl/mc_control_fsm_wait_timer.sv
// Memory-wait watchdog: counts consecutive stalled cycles, clears when the stall ends.
// Latency: timeout is combinational in the WAIT_LIMIT-th stalled cycle.
// Backpressure: none; WAIT_LIMIT=0 disables the timeout entirely.
module mc_wait_timer #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  output logic timeout
);

  if (WAIT_LIMIT > 0) begin : g_timer
    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_LIMIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
      if (rst || !hold) begin
        cnt <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + CW'(1);
      end
    end

    assign timeout = hold && (cnt == LAST);
  end else begin : g_no_timer
    assign timeout = 1'b0;
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute and issues datapath strobes.
// Latency: R 4, lw 5, sw 4, beq 3, j 3 cycles with memory always ready.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until mem_ready; faults after WAIT_LIMIT stalls.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input logic             clk,
  input logic             rst,
  mc_control_fsm_if.master bus
);

  state_t           state_q, state_d;
  fault_t           fault_q, fault_d;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl, strb;
  logic             hold, timeout, retire;

  assign hold = (state_q inside {FETCH, MEM_RD, MEM_WR}) && !bus.mem_ready;

  mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .hold    (hold),
    .timeout (timeout)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    ctrl    = '0;
    case (state_q)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = bus.mem_ready;
        ctrl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = DECODE;
        end else if (timeout) begin
          state_d = FAULT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        case (bus.opcode)
          OP_R:         state_d = EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          default: begin
            state_d = FAULT;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          state_d = FAULT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = FETCH;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d = FAULT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        state_d        = R_WB;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_d        = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        state_d            = FETCH;
      end
      JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        state_d        = FETCH;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Only completing states count, so a stalled FETCH looping on itself never retires.
  assign retire = (state_d == FETCH) && (state_q inside {MEM_WB, MEM_WR, R_WB, BRANCH, JUMP});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      fault_q   <= FAULT_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign strb = rst ? '0 : ctrl;

  assign bus.pc_write      = strb.pc_write;
  assign bus.pc_write_cond = strb.pc_write_cond;
  assign bus.pc_source     = strb.pc_source;
  assign bus.i_or_d        = strb.i_or_d;
  assign bus.mem_read      = strb.mem_read;
  assign bus.mem_write     = strb.mem_write;
  assign bus.ir_write      = strb.ir_write;
  assign bus.reg_dst       = strb.reg_dst;
  assign bus.mem_to_reg    = strb.mem_to_reg;
  assign bus.reg_write     = strb.reg_write;
  assign bus.alu_src_a     = strb.alu_src_a;
  assign bus.alu_src_b     = strb.alu_src_b;
  assign bus.alu_op        = strb.alu_op;
  assign bus.state         = state_q;
  assign bus.fault_code    = fault_q;
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle expectations queued at drive time, checked mid-cycle.
module tb_mc_control_fsm;

  localparam logic [3:0] S_F = 4'd0, S_DEC = 4'd1, S_MA = 4'd2, S_MRD = 4'd3, S_MWB = 4'd4,
                         S_MWR = 4'd5, S_EX = 4'd6, S_RWB = 4'd7, S_BR = 4'd8, S_J = 4'd9,
                         S_FLT = 4'd10;
  localparam logic [5:0] R = 6'h00, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, J = 6'h02, BAD = 6'h3F;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] ret_exp;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] strb;
    logic [1:0]  fc;
    logic [31:0] rc;
  } exp_t;
  exp_t scb[$];

  always #5 clk = ~clk;

  mc_control_fsm_if #(.CNT_W(32)) bus ();

  mc_control_fsm #(.WAIT_LIMIT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] strb_obs;
  assign strb_obs = {bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg, bus.reg_write,
                     bus.alu_src_a, bus.alu_src_b, bus.alu_op};

  function automatic logic [15:0] exp_strb(input logic [3:0] s, input logic rdy, input logic r);
    logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, sa;
    logic [1:0] ps, sb, ao;
    pw = 0; pwc = 0; iod = 0; mr = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0;
    ps = 2'b00; sb = 2'b00; ao = 2'b00;
    if (!r) begin
      case (s)
        S_F:   begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
        S_DEC: sb = 2'b11;
        S_MA:  begin sa = 1; sb = 2'b10; end
        S_MRD: begin mr = 1; iod = 1; end
        S_MWB: begin rw = 1; m2r = 1; end
        S_MWR: begin mw = 1; iod = 1; end
        S_EX:  begin sa = 1; ao = 2'b10; end
        S_RWB: begin rw = 1; rd = 1; end
        S_BR:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
        S_J:   begin pw = 1; ps = 2'b10; end
        default: ;
      endcase
    end
    return {pw, pwc, ps, iod, mr, mw, irw, rd, m2r, rw, sa, sb, ao};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs shortly after.
  task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                     input logic [3:0] es, input logic [1:0] ef);
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.opcode = op;
    bus.mem_ready = rdy;
    e.st = es; e.strb = exp_strb(es, rdy, r); e.fc = ef; e.rc = ret_exp;
    scb.push_back(e);
    #2;
    e = scb.pop_front();
    chk("state", 32'(bus.state), 32'(e.st));
    chk("strobes", 32'(strb_obs), 32'(e.strb));
    chk("fault_code", 32'(bus.fault_code), 32'(e.fc));
    chk("retired_count", bus.retired_count, e.rc);
    chk("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
    chk("pcw_excl", 32'(bus.pc_write & bus.pc_write_cond), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.opcode = R;
    bus.mem_ready = 1'b0;
    ret_exp = 0;
    repeat (2) @(posedge clk);

    // reset: strobes gated even with FETCH seeing mem_ready
    cyc(1, R, 1, S_F, 0);

    // R-type
    cyc(0, R, 1, S_F, 0); cyc(0, R, 1, S_DEC, 0); cyc(0, R, 1, S_EX, 0); cyc(0, R, 1, S_RWB, 0);
    ret_exp = 1;

    // lw with three stalled MEM_RD cycles
    cyc(0, LW, 1, S_F, 0); cyc(0, LW, 1, S_DEC, 0); cyc(0, LW, 1, S_MA, 0);
    repeat (3) cyc(0, LW, 0, S_MRD, 0);
    cyc(0, LW, 1, S_MRD, 0); cyc(0, LW, 1, S_MWB, 0);
    ret_exp = 2;

    // sw, FETCH stalled up to one cycle short of the limit
    repeat (3) cyc(0, SW, 0, S_F, 0);
    cyc(0, SW, 1, S_F, 0); cyc(0, SW, 1, S_DEC, 0); cyc(0, SW, 1, S_MA, 0); cyc(0, SW, 1, S_MWR, 0);
    ret_exp = 3;

    // beq, j
    cyc(0, BEQ, 1, S_F, 0); cyc(0, BEQ, 1, S_DEC, 0); cyc(0, BEQ, 1, S_BR, 0);
    ret_exp = 4;
    cyc(0, J, 1, S_F, 0); cyc(0, J, 1, S_DEC, 0); cyc(0, J, 1, S_J, 0);
    ret_exp = 5;

    // reset while MEM_WR is stalled
    cyc(0, SW, 1, S_F, 0); cyc(0, SW, 1, S_DEC, 0); cyc(0, SW, 1, S_MA, 0);
    cyc(0, SW, 0, S_MWR, 0); cyc(1, SW, 0, S_MWR, 0);
    ret_exp = 0;

    // illegal opcode: absorbing fault until reset
    cyc(0, BAD, 1, S_F, 0); cyc(0, BAD, 1, S_DEC, 0);
    repeat (20) cyc(0, BAD, 1'($urandom_range(0, 1)), S_FLT, 2'b01);
    cyc(1, BAD, 1, S_FLT, 2'b01);

    // memory timeout in FETCH
    repeat (4) cyc(0, R, 0, S_F, 0);
    repeat (3) cyc(0, R, 0, S_FLT, 2'b10);
    cyc(1, R, 1, S_FLT, 2'b10);
    cyc(0, R, 1, S_F, 0); cyc(0, R, 1, S_DEC, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
